// File: rtl/vga_rx_decoder.sv
// vga_rx_decoder: receive-side VGA timing recovery and pixel extractor.
// Registers the six display inputs and recovers line and frame timing from
// the sync pulses. It locks after one clean frame and then emits one
// coordinate/colour record per visible pixel.
//
// Optional feature: define VGA_RX_CRC_EN to build a per-frame CRC-16-CCITT
// over pix_rgbl.
//
// Ports:
//   clk, rst                : clock, synchronous active-high reset
//   hsync, vsync            : sync inputs, polarity set by SYNC_ACTIVE_LOW
//   red, green, blue, lum   : colour inputs
//   locked                  : timing locked
//   timing_err              : one-cycle pulse when a timing check fails
//   pix_valid               : one-cycle pulse per visible pixel
//   pix_x, pix_y            : pixel coordinate relative to the visible origin
//   pix_rgbl                : {red,green,blue,lum} of that pixel
//   frame_start             : pulse with pix_valid at pixel (0,0)
//   frame_crc, crc_valid    : CRC of the last complete frame, update strobe
module vga_rx_decoder #(
    parameter int unsigned H_VISIBLE       = 640,
    parameter int unsigned H_FRONT         = 16,
    parameter int unsigned H_SYNC          = 96,
    parameter int unsigned H_BACK          = 48,
    parameter int unsigned V_VISIBLE       = 480,
    parameter int unsigned V_FRONT         = 10,
    parameter int unsigned V_SYNC          = 2,
    parameter int unsigned V_BACK          = 33,
    parameter int unsigned CLKS_PER_PIXEL  = 1,
    parameter int unsigned SYNC_ACTIVE_LOW = 1,
    parameter int unsigned X_W             = 10,
    parameter int unsigned Y_W             = 10
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           hsync,
    input  logic           vsync,
    input  logic           red,
    input  logic           green,
    input  logic           blue,
    input  logic           lum,
    output logic           locked,
    output logic           timing_err,
    output logic           pix_valid,
    output logic [X_W-1:0] pix_x,
    output logic [Y_W-1:0] pix_y,
    output logic [3:0]     pix_rgbl,
    output logic           frame_start,
    output logic [15:0]    frame_crc,
    output logic           crc_valid
);

    localparam int unsigned H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned H_MAX     = H_TOTAL * CLKS_PER_PIXEL;
    localparam int unsigned HC_W      = $clog2(H_MAX + 1);
    localparam int unsigned VC_W      = $clog2(V_TOTAL + 1);
    localparam int unsigned H_VIS_LO  = H_SYNC + H_BACK;
    localparam int unsigned H_VIS_HI  = H_VIS_LO + H_VISIBLE;
    localparam int unsigned V_VIS_LO  = V_SYNC + V_BACK;
    localparam int unsigned V_VIS_HI  = V_VIS_LO + V_VISIBLE;
    localparam int unsigned SAMPLE_PH = CLKS_PER_PIXEL / 2;
    localparam logic        SYNC_ON   = (SYNC_ACTIVE_LOW != 0) ? 1'b0 : 1'b1;

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    state_t          state;
    logic            meas_sync;     // a frame boundary has been seen in MEASURE
    logic            hs_q;
    logic            vs_q;
    logic [3:0]      rgbl_q;
    logic [HC_W-1:0] h_cnt;
    logic [VC_W-1:0] v_cnt;
    logic            v_arm;

    logic            hs_edge;
    logic            vs_edge;
    logic            line_rst;
    logic            checking;
    logic            mismatch;
    logic [HC_W-1:0] h_pix;
    logic [HC_W-1:0] h_ph;
    logic            pix_hit;
    logic            pix_first;
    logic            pix_fire;

    // Edges compare the live input with its registered copy, so h_cnt/v_cnt
    // line up with the sample held in the input register.
    always_comb begin
        hs_edge   = (hsync == SYNC_ON) && (hs_q != SYNC_ON);
        vs_edge   = (vsync == SYNC_ON) && (vs_q != SYNC_ON);
        line_rst  = hs_edge && (v_arm || vs_edge);
        checking  = (state == LOCKED) || ((state == MEASURE) && meas_sync);
        mismatch  = checking &&
                    ((hs_edge && (h_cnt != HC_W'(H_MAX - 1))) ||
                     (h_cnt == HC_W'(H_MAX)) ||
                     (line_rst && (v_cnt != VC_W'(V_TOTAL - 1))));
        h_pix     = h_cnt / HC_W'(CLKS_PER_PIXEL);
        h_ph      = h_cnt % HC_W'(CLKS_PER_PIXEL);
        pix_hit   = (h_ph == HC_W'(SAMPLE_PH)) &&
                    (h_pix >= HC_W'(H_VIS_LO)) && (h_pix < HC_W'(H_VIS_HI)) &&
                    (v_cnt >= VC_W'(V_VIS_LO)) && (v_cnt < VC_W'(V_VIS_HI));
        pix_first = (h_pix == HC_W'(H_VIS_LO)) && (v_cnt == VC_W'(V_VIS_LO));
        pix_fire  = (state == LOCKED) && pix_hit && !mismatch;
    end

    // Input register, timing counters, lock FSM and pixel output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            hs_q        <= 1'b0;
            vs_q        <= 1'b0;
            rgbl_q      <= 4'h0;
            h_cnt       <= '0;
            v_cnt       <= '0;
            v_arm       <= 1'b0;
            state       <= SEARCH;
            meas_sync   <= 1'b0;
            locked      <= 1'b0;
            timing_err  <= 1'b0;
            pix_valid   <= 1'b0;
            pix_x       <= '0;
            pix_y       <= '0;
            pix_rgbl    <= 4'h0;
            frame_start <= 1'b0;
        end else begin
            hs_q   <= hsync;
            vs_q   <= vsync;
            rgbl_q <= {red, green, blue, lum};

            if (hs_edge) begin
                h_cnt <= '0;
            end else if (h_cnt != HC_W'(H_MAX)) begin
                h_cnt <= h_cnt + HC_W'(1);
            end

            // A vsync edge arms; the next hsync edge (or the same one) resets the frame.
            if (line_rst) begin
                v_cnt <= '0;
                v_arm <= 1'b0;
            end else begin
                if (vs_edge) begin
                    v_arm <= 1'b1;
                end
                if (hs_edge && (v_cnt != VC_W'(V_TOTAL))) begin
                    v_cnt <= v_cnt + VC_W'(1);
                end
            end

            timing_err  <= 1'b0;
            pix_valid   <= 1'b0;
            frame_start <= 1'b0;

            case (state)
                SEARCH: begin
                    locked <= 1'b0;
                    if (vs_edge) begin
                        state     <= MEASURE;
                        meas_sync <= line_rst;
                    end
                end
                MEASURE: begin
                    if (mismatch) begin
                        state      <= SEARCH;
                        meas_sync  <= 1'b0;
                        timing_err <= 1'b1;
                    end else if (line_rst) begin
                        if (meas_sync) begin
                            state  <= LOCKED;
                            locked <= 1'b1;
                        end else begin
                            meas_sync <= 1'b1;
                        end
                    end
                end
                LOCKED: begin
                    if (mismatch) begin
                        state      <= SEARCH;
                        meas_sync  <= 1'b0;
                        locked     <= 1'b0;
                        timing_err <= 1'b1;
                    end else if (pix_fire) begin
                        pix_valid   <= 1'b1;
                        pix_x       <= X_W'(h_pix - HC_W'(H_VIS_LO));
                        pix_y       <= Y_W'(v_cnt - VC_W'(V_VIS_LO));
                        pix_rgbl    <= rgbl_q;
                        frame_start <= pix_first;
                    end
                end
                default: begin
                    state  <= SEARCH;
                    locked <= 1'b0;
                end
            endcase
        end
    end

`ifdef VGA_RX_CRC_EN
    logic [15:0] crc_run;
    logic        last_q;
    logic        pix_last;

    // Shift one nibble, MSB first, into a CRC-16-CCITT register.
    function automatic logic [15:0] crc_nib(input logic [15:0] c, input logic [3:0] d);
        logic [15:0] r;
        r = c;
        for (int i = 3; i >= 0; i--) begin
            if (r[15] ^ d[i]) begin
                r = {r[14:0], 1'b0} ^ 16'h1021;
            end else begin
                r = {r[14:0], 1'b0};
            end
        end
        return r;
    endfunction

    always_comb begin
        pix_last = (h_pix == HC_W'(H_VIS_HI - 1)) && (v_cnt == VC_W'(V_VIS_HI - 1));
    end

    // Running CRC restarts at the first pixel; published the cycle after the last.
    always_ff @(posedge clk) begin
        if (rst) begin
            crc_run   <= 16'hFFFF;
            last_q    <= 1'b0;
            frame_crc <= 16'h0000;
            crc_valid <= 1'b0;
        end else begin
            crc_valid <= 1'b0;
            last_q    <= pix_fire && pix_last;
            if (pix_fire) begin
                crc_run <= crc_nib(pix_first ? 16'hFFFF : crc_run, rgbl_q);
            end else if ((state == LOCKED) && mismatch) begin
                crc_run <= 16'hFFFF;
            end
            if (last_q) begin
                frame_crc <= crc_run;
                crc_valid <= 1'b1;
            end
        end
    end
`else
    assign frame_crc = 16'h0000;
    assign crc_valid = 1'b0;
`endif

endmodule

// File: tb/tb_vga_rx_decoder.sv
// Scoreboard bench for vga_rx_decoder on a reduced 15x11 (8x6 visible)
// raster. The stimulus process drives frames and queues the expected
// pixel, timing_err, lock and CRC events with their cycle numbers. The
// monitor compares them every cycle on the falling edge.
module tb_vga_rx_decoder;

    localparam int HV = 8, HF = 2, HS = 3, HB = 2;
    localparam int VV = 6, VF = 1, VS = 2, VB = 2;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;
    localparam int HLO = HS + HB;
    localparam int VLO = VS + VB;

    logic        clk = 1'b0;
    logic        rst, hsync, vsync, red, green, blue, lum;
    logic        locked, timing_err, pix_valid, frame_start, crc_valid;
    logic [9:0]  pix_x, pix_y;
    logic [3:0]  pix_rgbl;
    logic [15:0] frame_crc;

    vga_rx_decoder #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .CLKS_PER_PIXEL(1), .SYNC_ACTIVE_LOW(1), .X_W(10), .Y_W(10)
    ) dut (
        .clk(clk), .rst(rst), .hsync(hsync), .vsync(vsync),
        .red(red), .green(green), .blue(blue), .lum(lum),
        .locked(locked), .timing_err(timing_err), .pix_valid(pix_valid),
        .pix_x(pix_x), .pix_y(pix_y), .pix_rgbl(pix_rgbl),
        .frame_start(frame_start), .frame_crc(frame_crc), .crc_valid(crc_valid)
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    logic rst_at_edge = 1'b0;
    always @(posedge clk) begin
        cyc         <= cyc + 1;
        rst_at_edge <= rst;
    end

    typedef struct { int cyc; int x; int y; logic [3:0] rgbl; logic fs; } pix_t;
    typedef struct { int cyc; logic v; } lk_t;
    typedef struct { int cyc; logic [15:0] crc; } crc_t;

    pix_t pixq[$];
    int   errq[$];
    lk_t  lockq[$];
    crc_t crcq[$];

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] crc_nib(input logic [15:0] c, input logic [3:0] d);
        logic [15:0] r;
        r = c;
        for (int i = 3; i >= 0; i--) begin
            if (r[15] ^ d[i]) r = {r[14:0], 1'b0} ^ 16'h1021;
            else              r = {r[14:0], 1'b0};
        end
        return r;
    endfunction

    // 0: all black, 1: single dot red+lum at (5,3), 2: coordinate gradient
    function automatic logic [3:0] pat_val(input int pat, input int x, input int y);
        if (pat == 1) return (x == 5 && y == 3) ? 4'b1001 : 4'b0000;
        if (pat == 2) return 4'(x * 3 + y * 5 + 1);
        return 4'b0000;
    endfunction

    task automatic drive(input logic hs, input logic vs, input logic [3:0] d, input logic r);
        @(posedge clk);
        #1;
        hsync = hs;
        vsync = vs;
        {red, green, blue, lum} = d;
        rst = r;
    endtask

    // One raster frame; optionally one line shortened by a pixel or a 1-clk reset.
    task automatic run_frame(input int pat, input bit pix_on, input bit lock_at_start,
                             input int short_line, input int rst_line);
        logic [15:0] crc;
        bit          alive;
        crc   = 16'hFFFF;
        alive = pix_on;
        for (int l = 0; l < VT; l++) begin
            for (int p = 0; p < HT; p++) begin
                bit         vis;
                int         x, y;
                logic [3:0] d;
                if (l == short_line && p == HT - 1) continue;
                x   = p - HLO;
                y   = l - VLO;
                vis = (x >= 0) && (x < HV) && (y >= 0) && (y < VV);
                d   = vis ? pat_val(pat, x, y) : 4'h0;
                drive(!(p < HS), !(l < VS), d, (l == rst_line && p == 0));
                if (l == 0 && p == 0 && lock_at_start) lockq.push_back('{cyc + 1, 1'b1});
                if (short_line >= 0 && l == short_line + 1 && p == 0) begin
                    errq.push_back(cyc + 1);
                    lockq.push_back('{cyc + 1, 1'b0});
                    alive = 1'b0;
                end
                if (rst_line >= 0 && l == rst_line && p == 0) begin
                    if (pix_on) lockq.push_back('{cyc + 1, 1'b0});
                    alive = 1'b0;
                end
                if (vis && alive) begin
                    pixq.push_back('{cyc + 2, x, y, d, (x == 0 && y == 0)});
                    crc = crc_nib((x == 0 && y == 0) ? 16'hFFFF : crc, d);
`ifdef VGA_RX_CRC_EN
                    if (x == HV - 1 && y == VV - 1 && short_line < 0 && rst_line < 0)
                        crcq.push_back('{cyc + 3, crc});
`endif
                end
            end
        end
    endtask

    // Monitor: pops whatever is due this cycle and compares against the DUT.
    logic exp_locked = 1'b0;
    always @(negedge clk) begin
        if (cyc >= 1) begin
            bit   exp_pv, exp_err, exp_cv;
            pix_t pe;
            crc_t ce;
            if (lockq.size() > 0 && lockq[0].cyc == cyc) begin
                exp_locked = lockq[0].v;
                void'(lockq.pop_front());
            end
            chk("locked", 64'(locked), 64'(exp_locked));

            exp_err = (errq.size() > 0 && errq[0] == cyc);
            if (exp_err) void'(errq.pop_front());
            chk("timing_err", 64'(timing_err), 64'(exp_err));

            exp_pv = (pixq.size() > 0 && pixq[0].cyc == cyc);
            chk("pix_valid", 64'(pix_valid), 64'(exp_pv));
            if (exp_pv) begin
                pe = pixq.pop_front();
                if (pix_valid)
                    chk("pixel_xy_rgbl_fs", {32'(pix_x), 16'(pix_y), 8'(pix_rgbl), 8'(frame_start)},
                        {32'(pe.x), 16'(pe.y), 8'(pe.rgbl), 8'(pe.fs)});
            end

            exp_cv = (crcq.size() > 0 && crcq[0].cyc == cyc);
            chk("crc_valid", 64'(crc_valid), 64'(exp_cv));
            if (exp_cv) begin
                ce = crcq.pop_front();
                if (crc_valid) chk("frame_crc", 64'(frame_crc), 64'(ce.crc));
            end
`ifndef VGA_RX_CRC_EN
            chk("frame_crc_zero", 64'(frame_crc), 64'd0);
`endif
            if (rst_at_edge)
                chk("reset_outputs",
                    {locked, timing_err, pix_valid, pix_x, pix_y, pix_rgbl, frame_start, frame_crc, crc_valid},
                    64'd0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        rst   = 1'b1;
        hsync = 1'($urandom);
        vsync = 1'($urandom);
        {red, green, blue, lum} = 4'($urandom);
        repeat (3) drive(1'($urandom), 1'($urandom), 4'($urandom), 1'b1);
        repeat (5) drive(1'b1, 1'b1, 4'h0, 1'b0);

        run_frame(0, 1'b0, 1'b0, -1, -1);   // first vsync edge: measuring
        run_frame(1, 1'b1, 1'b1, -1, -1);   // locks at start, dot at (5,3)
        run_frame(0, 1'b1, 1'b0, -1, -1);   // all-zero frame
        run_frame(2, 1'b1, 1'b0,  5, -1);   // line 5 one pixel short
        run_frame(2, 1'b0, 1'b0, -1, -1);   // remeasure
        run_frame(2, 1'b1, 1'b1, -1, -1);   // relocked
        run_frame(2, 1'b1, 1'b0, -1,  7);   // reset at line 7
        run_frame(2, 1'b0, 1'b0, -1, -1);   // remeasure
        run_frame(2, 1'b1, 1'b1, -1, -1);   // relocked

        // hsync stops: h_cnt saturates two cycles after the missing edge
        errq.push_back(cyc + 3);
        lockq.push_back('{cyc + 3, 1'b0});
        repeat (6) drive(1'b1, 1'b1, 4'h0, 1'b0);
        @(negedge clk);
        #1;
        chk("pix_queue_drained", 64'(pixq.size()), 64'd0);
        chk("err_queue_drained", 64'(errq.size()), 64'd0);
        chk("crc_queue_drained", 64'(crcq.size()), 64'd0);
        chk("lock_queue_drained", 64'(lockq.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_rx_decoder.md
Name: vga_rx_decoder

Overview:
- Receive-side counterpart of the mini-VGA output stage. Samples hsync, vsync, red, green, blue and lum, recovers line/frame timing, locks to it, and emits per-pixel coordinates and colour.
- Used as an on-chip loopback checker and as the bench-side monitor for display outputs, all in the same clock domain as the generator.

Parameters:
- H_VISIBLE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_VISIBLE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BACK, 33, vertical back porch (lines)
- CLKS_PER_PIXEL, 1, clk cycles per pixel (>=1)
- SYNC_ACTIVE_LOW, 1, 1 = sync pulses are active-low
- X_W, 10, pix_x width
- Y_W, 10, pix_y width

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- hsync  in  1  horizontal sync
- vsync  in  1  vertical sync
- red  in  1  red
- green  in  1  green
- blue  in  1  blue
- lum  in  1  luminance
- locked  out  1  timing locked
- timing_err  out  1  one-cycle pulse on timing mismatch
- pix_valid  out  1  one-cycle pulse per visible pixel
- pix_x  out  X_W  pixel column
- pix_y  out  Y_W  pixel row
- pix_rgbl  out  4  {red,green,blue,lum}
- frame_start  out  1  pulse coincident with pix_valid at (0,0)
- frame_crc  out  16  CRC of last frame (optional feature)
- crc_valid  out  1  one-cycle pulse when frame_crc updates

Behaviour:
- Reset: rst is sampled on the rising edge of clk. While rst=1:
  - all outputs are 0; FSM goes to SEARCH;
  - the input register, all counters and the vsync arm flag clear.
- Input stage: one register stage on all six inputs. Assertion edge = sync goes active after being inactive in the previous registered sample; polarity per SYNC_ACTIVE_LOW.
- Counters:
  - h_cnt counts clk cycles. It is set to 0 on the hsync assertion edge and otherwise increments, saturating at H_TOTAL*CLKS_PER_PIXEL, where H_TOTAL is the sum of the four H parameters.
  - A vsync assertion edge sets the arm flag.
  - On the next hsync assertion edge (or the same cycle), v_cnt is set to 0 and the arm flag clears.
  - Any other hsync assertion edge increments v_cnt, saturating at V_TOTAL.
- Visible region:
  - columns: h_cnt/CLKS_PER_PIXEL in [H_SYNC+H_BACK, H_SYNC+H_BACK+H_VISIBLE);
  - lines: v_cnt in [V_SYNC+V_BACK, V_SYNC+V_BACK+V_VISIBLE).
- Pixel sampling: the sample point is the cycle where h_cnt mod CLKS_PER_PIXEL == CLKS_PER_PIXEL/2 (integer division).
- Output registers: pix_x, pix_y and pix_rgbl are relative to the visible origin. They are registered and hold their value between pulses.
- Latency: pix_valid rises 2 clk after the input edge carrying the sampled pixel (1 input register + 1 output register).
- FSM SEARCH:
  - locked=0, no pix_valid.
  - vsync assertion edge -> MEASURE.
- FSM MEASURE:
  - Every hsync edge must arrive with h_cnt == H_TOTAL*CLKS_PER_PIXEL-1.
  - The next vsync-armed line reset must occur with v_cnt == V_TOTAL-1.
  - Both hold for one full frame -> LOCKED; locked=1 from the cycle after.
  - Any mismatch, or h_cnt saturating -> SEARCH, timing_err pulse.
- FSM LOCKED: pix_valid is enabled. Any mismatch of the MEASURE checks -> SEARCH:
  - timing_err pulses;
  - locked drops the same cycle as timing_err;
  - no further pix_valid is issued.
- Simultaneous events:
  - hsync and vsync edge in the same cycle: the line reset wins; v_cnt=0.
  - A mismatch on the last pixel's cycle suppresses that pix_valid.
- rst mid-frame: immediate return to SEARCH with no timing_err. At least one full clean frame is needed to relock.

Optional Feature:
- Macro: VGA_RX_CRC_EN.
- Defined:
  - CRC-16-CCITT, poly 0x1021, init 0xFFFF, runs over pix_rgbl. Each pix_valid shifts in 4 bits, MSB (red) first.
  - The register re-inits at frame_start.
  - After the final visible pixel (H_VISIBLE-1, V_VISIBLE-1): frame_crc is loaded, and crc_valid pulses 1 cycle after that pix_valid.
  - Loss of lock discards the partial CRC.
- Not defined: frame_crc=0 and crc_valid=0 constantly; no CRC logic.

Test Plan:
- Reset: hold rst=1 for 4 clk with random inputs -> all outputs 0; locked=0 after release.
- Nominal lock: default 640x480 timing (800x525 totals), CLKS_PER_PIXEL=1:
  - locked=0 through the first frame after the first vsync edge;
  - locked=1 after the second vsync-armed line reset;
  - exactly 307200 pix_valid per subsequent frame.
- Coordinates/colour: drive red=1, lum=1 only at visible pixel (5,3) ->
  - pix_valid with pix_x=5, pix_y=3, pix_rgbl=4'b1001 exactly 2 clk after that input;
  - frame_start pulses with (0,0).
- Timing error: while locked, shorten one line to 799 pixels -> timing_err single pulse, locked=0 the same cycle, no pix_valid until the next full clean frame relocks.
- Mid-frame reset: rst for 1 clk at line 200 -> outputs 0, no timing_err, relock after one clean frame.
- CRC (VGA_RX_CRC_EN): all-zero frame -> crc_valid once per frame with frame_crc equal to the bench model's CRC of 307200 zero nibbles. Without the macro, crc_valid stays 0.
